// File: rtl/goboard_hex_pager_if.sv
// Display-pager bus: debug word/strobe, button and auto-mode inputs, nibble and LED outputs.
interface goboard_hex_pager_if;
   logic [31:0] word_i;
   logic        load_i;
   logic        btn_i;
   logic        auto_i;
   logic [3:0]  hi_nib_o;
   logic [3:0]  lo_nib_o;
   logic [3:0]  led_o;

   modport master (
      output word_i, load_i, btn_i, auto_i,
      input  hi_nib_o, lo_nib_o, led_o
   );

   modport slave (
      input  word_i, load_i, btn_i, auto_i,
      output hi_nib_o, lo_nib_o, led_o
   );
endinterface

// File: rtl/goboard_hex_pager.sv
// Pages a snapshotted 32-bit debug word onto two hex digits, one byte per page,
// advancing on a debounced button press or an optional free-running timer.
module goboard_hex_pager #(
   parameter int unsigned PAGE_CYCLES     = 12_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
   input logic                clk,
   input logic                rst_n,
   goboard_hex_pager_if.slave bus
);

   localparam int unsigned    PGW     = $clog2(PAGE_CYCLES);
   localparam int unsigned    DBW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PGW-1:0] PG_LAST = PGW'(PAGE_CYCLES - 1);
   localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} db_state_t;

   logic [1:0]     r_sync;
   logic           w_btn_s;
   db_state_t      r_state, w_state_nxt;
   logic [DBW-1:0] r_db_cnt, w_db_cnt_nxt;
   logic           w_press;
   logic [31:0]    r_snap;
   logic [1:0]     r_page;
   logic [PGW-1:0] r_pg_cnt;
   logic           w_tick;
   logic [7:0]     w_byte;
   logic [3:0]     r_hi, r_lo, r_led;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[0], bus.btn_i};
   end
   assign w_btn_s = r_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE_LO;
         r_db_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_db_cnt <= w_db_cnt_nxt;
      end
   end

   // press is Mealy: it fires in the cycle the count completes, so the page moves on that edge
   always_comb begin
      w_state_nxt  = r_state;
      w_db_cnt_nxt = r_db_cnt;
      w_press      = 1'b0;
      case (r_state)
         IDLE_LO: if (w_btn_s) begin
            w_state_nxt  = WAIT_HI;
            w_db_cnt_nxt = DBW'(1);
         end
         WAIT_HI: if (!w_btn_s) begin
            w_state_nxt  = IDLE_LO;
            w_db_cnt_nxt = '0;
         end else if (r_db_cnt == DB_MAX) begin
            w_state_nxt  = IDLE_HI;
            w_db_cnt_nxt = '0;
            w_press      = 1'b1;
         end else begin
            w_db_cnt_nxt = r_db_cnt + 1'b1;
         end
         IDLE_HI: if (!w_btn_s) begin
            w_state_nxt  = WAIT_LO;
            w_db_cnt_nxt = DBW'(1);
         end
         WAIT_LO: if (w_btn_s) begin
            w_state_nxt  = IDLE_HI;
            w_db_cnt_nxt = '0;
         end else if (r_db_cnt == DB_MAX) begin
            w_state_nxt  = IDLE_LO;
            w_db_cnt_nxt = '0;
         end else begin
            w_db_cnt_nxt = r_db_cnt + 1'b1;
         end
         default: begin
            w_state_nxt  = IDLE_LO;
            w_db_cnt_nxt = '0;
         end
      endcase
   end

   assign w_tick = bus.auto_i && (r_pg_cnt == PG_LAST);

   // load beats press beats tick; a press also restarts the page timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap   <= '0;
         r_page   <= '0;
         r_pg_cnt <= '0;
      end else if (bus.load_i) begin
         r_snap   <= bus.word_i;
         r_page   <= '0;
         r_pg_cnt <= '0;
      end else if (w_press || w_tick) begin
         r_page   <= r_page + 2'd1;
         r_pg_cnt <= '0;
      end else if (bus.auto_i) begin
         r_pg_cnt <= r_pg_cnt + 1'b1;
      end else begin
         r_pg_cnt <= '0;
      end
   end

   always_comb begin
      w_byte = '0;
      case (r_page)
         2'd0: w_byte = r_snap[31:24];
         2'd1: w_byte = r_snap[23:16];
         2'd2: w_byte = r_snap[15:8];
         2'd3: w_byte = r_snap[7:0];
         default: w_byte = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_led <= 4'b0001;
      end else begin
         r_hi  <= w_byte[7:4];
         r_lo  <= w_byte[3:0];
         r_led <= 4'b0001 << r_page;
      end
   end

   assign bus.hi_nib_o = r_hi;
   assign bus.lo_nib_o = r_lo;
   assign bus.led_o    = r_led;

endmodule

// File: doc/goboard_hex_pager.md
# goboard_hex_pager

Upstream feeder for the Go Board's two seven-segment digit decoders. It snapshots a 32-bit debug word from the ARM single-cycle core on a load strobe. It then presents that word one byte at a time as two 4-bit nibbles, one per digit decoder. Pages advance on a debounced pushbutton press or, optionally, on a free-running timer. A one-hot LED output shows which byte is on display.

## Interface
- `PAGE_CYCLES`, default 12_000_000: clock cycles per auto-advance; 1 s at 12 MHz. Legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 120_000: consecutive stable cycles required to accept a button level change; 10 ms. Legal range ≥ 1.
- `clk`  in  1  12 MHz board clock; the only clock in the block.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `word_i`  in  32  debug word to display.
- `load_i`  in  1  single-cycle strobe; captures `word_i`.
- `btn_i`  in  1  raw pushbutton, active-high, asynchronous to `clk`, bouncy.
- `auto_i`  in  1  1 = timer auto-advance enabled. Level, synchronous to `clk`.
- `hi_nib_o`  out  4  upper nibble of the displayed byte; drives the left digit decoder.
- `lo_nib_o`  out  4  lower nibble of the displayed byte; drives the right digit decoder.
- `led_o`  out  4  one-hot page indicator; bit p set when page p is displayed.

## Operation
- **Snapshot register (32 b).** Loaded from `word_i` on any edge where `load_i`=1. It holds until the next load.
- **Page register (2 b).** Page p selects byte `snap[31-8p -: 8]`, so page 0 shows the MS byte and page 3 shows the LS byte. Increments modulo 4, so 3 wraps to 0.
- **Button synchronizer.** Two flops on `btn_i`, producing `btn_s`.
- **Debounce FSM.** States IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. A shared counter `db_cnt` holds ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - IDLE_LO, `btn_s`=1: go to WAIT_HI, `db_cnt`=1.
  - WAIT_HI, `btn_s`=0: go to IDLE_LO, `db_cnt`=0 (bounce rejected).
  - WAIT_HI, `btn_s`=1 and `db_cnt`=DEBOUNCE_CYCLES: go to IDLE_HI and emit `press` for exactly one cycle.
  - WAIT_HI otherwise: `db_cnt`++.
  - IDLE_HI / WAIT_LO mirror the above with polarity inverted. No pulse on release.
- **Page timer.** `pg_cnt` counts 0..PAGE_CYCLES-1 while `auto_i`=1.
  - `tick` is asserted on the cycle `pg_cnt`=PAGE_CYCLES-1; `pg_cnt` wraps to 0.
  - `auto_i`=0 holds `pg_cnt` at 0 and suppresses `tick`.
- **Priority per edge:** `load_i` > `press` > `tick`.
  - load: capture snapshot, page←0, `pg_cnt`←0; any press/tick that cycle is dropped.
  - press: page++, `pg_cnt`←0; a coincident tick is dropped, giving a single advance.
  - tick: page++.
- **Output registers.** `hi_nib_o`/`lo_nib_o` are registered from the selected snapshot byte. `led_o` is registered as 1<<page.

## Timing
- **Reset values:** snapshot 0, page 0, `pg_cnt` 0, `db_cnt` 0, FSM IDLE_LO, sync flops 0, `hi_nib_o`=0, `lo_nib_o`=0, `led_o`=4'b0001.
- **Mid-operation reset:** everything returns to reset values immediately (asynchronous). First update is on the first edge after `rst_n` rises.
- **Load latency:** `load_i` high at edge k updates snapshot and page at k. New nibbles and `led_o` are visible after edge k+1 (2-cycle latency).
- **Button latency:** `btn_i` rises and stays stable. `btn_s` goes high 2 edges later. `press` is high during the cycle after DEBOUNCE_CYCLES further edges. Page updates on that edge; outputs follow 1 edge later.
- **Bounce rejection:** any `btn_s` glitch shorter than DEBOUNCE_CYCLES cycles produces no `press` and leaves the FSM in its idle state.
- **Holding the button:** exactly one press per debounced rising level, with no auto-repeat.
- **Auto-advance rate:** with `auto_i`=1 and no other events, page advances every PAGE_CYCLES cycles exactly.
- **`load_i` held high:** recaptures every cycle and holds page and `pg_cnt` at 0.

## Test plan
Run with PAGE_CYCLES=8, DEBOUNCE_CYCLES=4.
1. **Reset.** `rst_n`=0 with random inputs -> `hi_nib_o`=0, `lo_nib_o`=0, `led_o`=4'b0001. Assert mid-run to confirm the asynchronous clear.
2. **Load.** Load 0xDEADBEEF with `auto_i`=0 -> after 2 edges, hi=0xD, lo=0xE, led=0001. Hold indefinitely with no change.
3. **Auto paging.** `auto_i`=1 after loading 0x12345678 -> bytes 0x12, 0x34, 0x56, 0x78, 0x12 appear at exact 8-cycle intervals. `led_o` walks 0001, 0010, 0100, 1000, 0001.
4. **Debounce.**
   - Bounce `btn_i` high for 3 cycles, low for 2, repeated 3×, then hold high 20 cycles -> exactly one advance.
   - Release with bounce -> no advance.
   - Check advance latency = 2+4+1 edges from the stable rise to the page change.
5. **Priority collisions.**
   - Force `load_i` on the same edge as `press` -> page=0 and new word shown.
   - Force `press` on the tick edge -> single advance, and next tick arrives 8 cycles later.
6. **Wrap and disable.**
   - Four presses from page 0 -> return to page 0 with led=0001.
   - Drop `auto_i` mid-count -> no tick. Re-enable -> full 8 cycles to the next advance.
